// File: rtl/silife_grid_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | silife_grid_arbiter_if                                                     |
// | Row-write requests in, granted row data and generation strobe out.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface silife_grid_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int N_REQ  = 3
);
    localparam int ROW_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [N_REQ-1:0]          i_req;
    logic [N_REQ-1:0]          i_lock;
    logic [N_REQ*ROW_BITS-1:0] i_row;
    logic [N_REQ*WIDTH-1:0]    i_set_cells;
    logic [N_REQ*WIDTH-1:0]    i_clear_cells;
    logic                      i_gen_req;

    logic [N_REQ-1:0]          o_gnt;
    logic [ROW_BITS-1:0]       o_row_select;
    logic [WIDTH-1:0]          o_set_cells;
    logic [WIDTH-1:0]          o_clear_cells;
    logic                      o_gen_enable;
    logic                      o_gen_pending;
    logic                      o_timeout;

    modport slave (
        input  i_req, i_lock, i_row, i_set_cells, i_clear_cells, i_gen_req,
        output o_gnt, o_row_select, o_set_cells, o_clear_cells,
               o_gen_enable, o_gen_pending, o_timeout
    );

    modport master (
        output i_req, i_lock, i_row, i_set_cells, i_clear_cells, i_gen_req,
        input  o_gnt, o_row_select, o_set_cells, o_clear_cells,
               o_gen_enable, o_gen_pending, o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/silife_grid_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | silife_grid_arbiter                                                        |
// | Round-robin row-port arbiter with burst lock, watchdog and gen scheduling. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module silife_grid_arbiter #(
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 32,
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 64
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    silife_grid_arbiter_if.slave bus
);
    localparam int c_ROW_BITS  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_RR_BITS   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_HOLD_BITS = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HOLD_BITS-1:0] c_HOLD_LAST = c_HOLD_BITS'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GEN   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [N_REQ-1:0]       r_gnt;
    logic [c_RR_BITS-1:0]   r_rr;
    logic [c_HOLD_BITS-1:0] r_hold_cnt;
    logic                   r_gen_pending;
    logic                   r_timeout;

    state_t                 w_state_nxt;
    logic [N_REQ-1:0]       w_gnt_nxt;
    logic [c_RR_BITS-1:0]   w_rr_nxt;
    logic [c_HOLD_BITS-1:0] w_hold_nxt;
    logic                   w_pending_nxt;
    logic                   w_timeout_nxt;
    logic                   w_pending_eff;
    logic                   w_holder_locked;
    logic                   w_continue;
    logic                   w_found;
    int                     w_idx;

    logic [c_ROW_BITS-1:0]  w_row_sel;
    logic [WIDTH-1:0]       w_set;
    logic [WIDTH-1:0]       w_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_rr          <= '0;
            r_hold_cnt    <= '0;
            r_gen_pending <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_rr          <= w_rr_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_gen_pending <= w_pending_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign w_pending_eff   = r_gen_pending | bus.i_gen_req;
    assign w_holder_locked = |(r_gnt & bus.i_req & bus.i_lock);
    assign w_continue      = (r_state == S_GRANT) && w_holder_locked && (r_hold_cnt != c_HOLD_LAST);

    always_comb begin
        w_state_nxt   = S_IDLE;
        w_gnt_nxt     = '0;
        w_rr_nxt      = r_rr;
        w_hold_nxt    = '0;
        w_pending_nxt = w_pending_eff;
        w_timeout_nxt = 1'b0;
        w_found       = 1'b0;
        w_idx         = 0;

        if (w_continue) begin
            w_state_nxt = S_GRANT;
            w_gnt_nxt   = r_gnt;
            w_hold_nxt  = r_hold_cnt + 1'b1;
        end else begin
            // Holder still wants the port here only if the watchdog expired
            w_timeout_nxt = (r_state == S_GRANT) && w_holder_locked;
            if (w_pending_eff && (r_state != S_GEN)) begin
                w_state_nxt   = S_GEN;
                w_pending_nxt = 1'b0;
            end else if (!w_pending_eff) begin
                for (int i = 0; i < N_REQ; i++) begin
                    w_idx = int'(r_rr) + i;
                    if (w_idx >= N_REQ) begin
                        w_idx = w_idx - N_REQ;
                    end
                    if (!w_found && bus.i_req[w_idx]) begin
                        w_found          = 1'b1;
                        w_state_nxt      = S_GRANT;
                        w_gnt_nxt[w_idx] = 1'b1;
                        w_rr_nxt         = (w_idx == N_REQ - 1) ? '0 : c_RR_BITS'(w_idx + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_row_sel = '0;
        w_set     = '0;
        w_clr     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gnt[k]) begin
                w_row_sel = w_row_sel | bus.i_row[k*c_ROW_BITS +: c_ROW_BITS];
                w_set     = w_set     | bus.i_set_cells[k*WIDTH +: WIDTH];
                w_clr     = w_clr     | bus.i_clear_cells[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.o_gnt         = r_gnt;
    assign bus.o_row_select  = w_row_sel;
    assign bus.o_set_cells   = w_set;
    assign bus.o_clear_cells = w_clr;
    assign bus.o_gen_enable  = (r_state == S_GEN);
    assign bus.o_gen_pending = r_gen_pending;
    assign bus.o_timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_silife_grid_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_silife_grid_arbiter                                                     |
// | Vector table + scoreboard bench; DUT A uses MAX_HOLD=64, DUT B MAX_HOLD=4. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_silife_grid_arbiter;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int N  = 3;
    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic          gen_req;
    logic [RB-1:0] rows [N];
    logic [W-1:0]  sets [N];
    logic [W-1:0]  clrs [N];

    typedef struct {
        logic         rst;
        logic         sel;
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic         gen;
        logic [N-1:0] egnt;
        logic         een;
        logic         epend;
        logic         eto;
    } vec_t;

    typedef struct {
        logic         sel;
        logic [N-1:0] gnt;
        logic         en;
        logic         pend;
        logic         to;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    silife_grid_arbiter_if #(.WIDTH(W), .HEIGHT(H), .N_REQ(N)) bus_a ();
    silife_grid_arbiter_if #(.WIDTH(W), .HEIGHT(H), .N_REQ(N)) bus_b ();

    assign bus_a.i_req         = req;
    assign bus_a.i_lock        = lock;
    assign bus_a.i_gen_req     = gen_req;
    assign bus_a.i_row         = {rows[2], rows[1], rows[0]};
    assign bus_a.i_set_cells   = {sets[2], sets[1], sets[0]};
    assign bus_a.i_clear_cells = {clrs[2], clrs[1], clrs[0]};
    assign bus_b.i_req         = req;
    assign bus_b.i_lock        = lock;
    assign bus_b.i_gen_req     = gen_req;
    assign bus_b.i_row         = {rows[2], rows[1], rows[0]};
    assign bus_b.i_set_cells   = {sets[2], sets[1], sets[0]};
    assign bus_b.i_clear_cells = {clrs[2], clrs[1], clrs[0]};

    silife_grid_arbiter #(.WIDTH(W), .HEIGHT(H), .N_REQ(N), .MAX_HOLD(64)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    silife_grid_arbiter #(.WIDTH(W), .HEIGHT(H), .N_REQ(N), .MAX_HOLD(4)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    task automatic add(input logic rst, input logic sel, input logic [N-1:0] r,
                       input logic [N-1:0] l, input logic g, input logic [N-1:0] eg,
                       input logic een, input logic ep, input logic eto);
        vec_t v;
        v.rst = rst; v.sel = sel; v.req = r; v.lock = l; v.gen = g;
        v.egnt = eg; v.een = een; v.epend = ep; v.eto = eto;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e, input string tag);
        logic [N-1:0]  a_gnt;
        logic [RB-1:0] a_row;
        logic [W-1:0]  a_set, a_clr;
        logic          a_en, a_pend, a_to;
        logic [RB-1:0] m_row;
        logic [W-1:0]  m_set, m_clr;
        if (e.sel) begin
            a_gnt = bus_b.o_gnt; a_row = bus_b.o_row_select; a_set = bus_b.o_set_cells;
            a_clr = bus_b.o_clear_cells; a_en = bus_b.o_gen_enable;
            a_pend = bus_b.o_gen_pending; a_to = bus_b.o_timeout;
        end else begin
            a_gnt = bus_a.o_gnt; a_row = bus_a.o_row_select; a_set = bus_a.o_set_cells;
            a_clr = bus_a.o_clear_cells; a_en = bus_a.o_gen_enable;
            a_pend = bus_a.o_gen_pending; a_to = bus_a.o_timeout;
        end
        m_row = '0; m_set = '0; m_clr = '0;
        for (int k = 0; k < N; k++) begin
            if (e.gnt[k]) begin
                m_row = rows[k]; m_set = sets[k]; m_clr = clrs[k];
            end
        end
        cmp({tag, " gnt"},     32'(a_gnt),  32'(e.gnt));
        cmp({tag, " row"},     32'(a_row),  32'(m_row));
        cmp({tag, " set"},     a_set,       m_set);
        cmp({tag, " clear"},   a_clr,       m_clr);
        cmp({tag, " gen_en"},  32'(a_en),   32'(e.en));
        cmp({tag, " pending"}, 32'(a_pend), 32'(e.pend));
        cmp({tag, " timeout"}, 32'(a_to),   32'(e.to));
        cmp({tag, " gen_and_gnt"}, 32'(a_en & (|a_gnt)), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = '0; lock = '0; gen_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: got empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check_outputs(e, tag);
        end
    endtask

    initial begin
        exp_t z;
        rows[0] = 5'd5;  rows[1] = 5'd12; rows[2] = 5'd19;
        sets[0] = 32'hDEAD_BEEF; sets[1] = 32'h1234_5678; sets[2] = 32'hCAFE_F00D;
        clrs[0] = 32'h0F0F_0F0F; clrs[1] = 32'h8000_0001; clrs[2] = 32'h5555_AAAA;
        reset_n = 1'b0; req = '0; lock = '0; gen_req = 1'b0;

        // Round robin, all unlocked
        for (int i = 0; i < 6; i++) add(i == 0, 0, 3'b111, 3'b000, 0, 3'b001 << (i % 3), 0, 0, 0);
        add(0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0);
        // Requester 1 burst of 10, requester 2 follows with no gap
        for (int i = 0; i < 10; i++) add(i == 0, 0, 3'b110, 3'b010, 0, 3'b010, 0, 0, 0);
        add(0, 0, 3'b100, 3'b000, 0, 3'b100, 0, 0, 0);
        add(0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0);
        // Watchdog on DUT B (MAX_HOLD=4)
        for (int i = 0; i < 4; i++) add(i == 0, 1, 3'b111, 3'b001, 0, 3'b001, 0, 0, 0);
        add(0, 1, 3'b111, 3'b001, 0, 3'b010, 0, 0, 1);
        add(0, 1, 3'b111, 3'b001, 0, 3'b100, 0, 0, 0);
        add(0, 1, 3'b111, 3'b001, 0, 3'b001, 0, 0, 0);
        add(0, 1, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0);
        // Generation requested twice during a 5-cycle burst
        add(1, 0, 3'b101, 3'b001, 0, 3'b001, 0, 0, 0);
        add(0, 0, 3'b101, 3'b001, 1, 3'b001, 0, 1, 0);
        add(0, 0, 3'b101, 3'b001, 1, 3'b001, 0, 1, 0);
        add(0, 0, 3'b101, 3'b001, 0, 3'b001, 0, 1, 0);
        add(0, 0, 3'b101, 3'b001, 0, 3'b001, 0, 1, 0);
        add(0, 0, 3'b100, 3'b000, 0, 3'b000, 1, 0, 0);
        add(0, 0, 3'b100, 3'b000, 0, 3'b100, 0, 0, 0);
        add(0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0);
        // Simultaneous gen and req on idle port, then gen re-requested during GEN
        add(1, 0, 3'b100, 3'b000, 1, 3'b000, 1, 0, 0);
        add(0, 0, 3'b100, 3'b000, 0, 3'b100, 0, 0, 0);
        add(0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0);
        add(0, 0, 3'b000, 3'b000, 1, 3'b000, 1, 0, 0);
        add(0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 1, 0);
        add(0, 0, 3'b000, 3'b000, 0, 3'b000, 1, 0, 0);
        add(0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0);

        @(posedge clk);
        #1;
        z.sel = 1'b0; z.gnt = '0; z.en = 1'b0; z.pend = 1'b0; z.to = 1'b0;
        check_outputs(z, "reset_a");
        z.sel = 1'b1;
        check_outputs(z, "reset_b");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            if (vecs[i].rst) do_reset();
            req = vecs[i].req; lock = vecs[i].lock; gen_req = vecs[i].gen;
            e.sel = vecs[i].sel; e.gnt = vecs[i].egnt; e.en = vecs[i].een;
            e.pend = vecs[i].epend; e.to = vecs[i].eto;
            sb.push_back(e);
            @(posedge clk);
            #1;
            pop_and_check($sformatf("v%0d", i));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a locked grant
        do_reset();
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            req = 3'b010; lock = 3'b010; gen_req = 1'b0;
            e.sel = 1'b0; e.gnt = 3'b010; e.en = 1'b0; e.pend = 1'b0; e.to = 1'b0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            pop_and_check($sformatf("async_pre%0d", i));
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        z.sel = 1'b0;
        check_outputs(z, "async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        begin
            exp_t e;
            req = 3'b111; lock = 3'b000;
            e.sel = 1'b0; e.gnt = 3'b001; e.en = 1'b0; e.pend = 1'b0; e.to = 1'b0;
            sb.push_back(e);
            @(posedge clk);
            #1;
            pop_and_check("async_post");
        end
        @(negedge clk);
        req = '0;

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
